// File: rtl/uart_pkg.sv
// Shared UART constants: frame geometry and transmit shifter state encodings.
// Used by both the transmitter and the 16x receiver.
package uart_pkg;

   localparam int TICKS_PER_BIT = 16;
   localparam int DATA_BITS     = 8;
   localparam int STOP_BITS     = 1;
   localparam int TICK_W        = $clog2(TICKS_PER_BIT);
   localparam int BIT_IDX_W     = $clog2(DATA_BITS);

   // Receiver samples each bit at its centre tick.
   localparam int RX_SAMPLE_TICK = TICKS_PER_BIT / 2 - 1;

   typedef logic [1:0] uart_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   function automatic logic is_last_tick(input logic [TICK_W-1:0] cnt);
      return cnt == TICK_W'(TICKS_PER_BIT - 1);
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous byte FIFO with first-word fall-through read, so the
// shifter can load the head byte on the same edge that pops it.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic [PTR_W:0]       count,
   output logic                 full,
   output logic                 empty
);

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter paced by the 16x oversampling tick, fed from a byte
// FIFO so queued bytes go out as contiguous frames.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 uart_tick_16x,
   input  logic                 write,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 ready,
   output logic                 TxD,
   output logic                 busy,
   output logic [PTR_W:0]       fifo_count
);

   uart_state_t          state_q, state_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 txd_q, txd_d;

   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_dout;
   logic                 last_tick;

   uart_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (write),
      .pop   (fifo_pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ready     = ~fifo_full;
   assign TxD       = txd_q;
   assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
   assign last_tick = is_last_tick(tick_cnt_q);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      txd_d      = txd_q;
      fifo_pop   = 1'b0;

      if (uart_tick_16x) begin
         case (state_q)
            ST_IDLE: begin
               txd_d = 1'b1;
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_d    = fifo_dout;
                  txd_d      = 1'b0;
                  tick_cnt_d = '0;
                  state_d    = ST_START;
               end
            end

            ST_START: begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               if (last_tick) begin
                  txd_d     = shift_q[0];
                  bit_idx_d = '0;
                  state_d   = ST_DATA;
               end
            end

            ST_DATA: begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               if (last_tick) begin
                  if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                     txd_d   = 1'b1;
                     state_d = ST_STOP;
                  end else begin
                     shift_d   = shift_q >> 1;
                     txd_d     = shift_q[1];
                     bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                  end
               end
            end

            ST_STOP: begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               // Chain straight into the next START so busy never dips.
               if (last_tick) begin
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     shift_d  = fifo_dout;
                     txd_d    = 1'b0;
                     state_d  = ST_START;
                  end else begin
                     state_d  = ST_IDLE;
                  end
               end
            end

            default: begin
               txd_d   = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one task per scenario, ticks every 4 clocks,
// outputs sampled on the falling edge.
module tb_uart_tx_fifo;

   logic       clock;
   logic       reset;
   logic       uart_tick_16x;
   logic       write;
   logic [7:0] data_in;
   logic       ready;
   logic       TxD;
   logic       busy;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(.FIFO_DEPTH(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .uart_tick_16x (uart_tick_16x),
      .write         (write),
      .data_in       (data_in),
      .ready         (ready),
      .TxD           (TxD),
      .busy          (busy),
      .fifo_count    (fifo_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1);
   end

   task automatic tick_once();
      uart_tick_16x = 1'b1;
      @(negedge clock);
      uart_tick_16x = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic wr(input logic [7:0] b);
      write   = 1'b1;
      data_in = b;
      @(negedge clock);
      write   = 1'b0;
   endtask

   task automatic apply_reset();
      #2 reset = 1'b0;
      #2;
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Ticks n=0..159 of one frame; n=0 is the START entry edge.
   task automatic run_frame(input logic [7:0] b);
      logic [7:0] rx;
      logic       exp;
      rx = 8'h00;
      for (int n = 0; n < 160; n++) begin
         tick_once();
         if (n < 16)       exp = 1'b0;
         else if (n < 144) exp = b[(n - 16) / 16];
         else              exp = 1'b1;
         checks++;
         if (TxD !== exp) begin
            errors++;
            $display("FAIL txd_wave byte=%h tick=%0d got %b want %b", b, n, TxD, exp);
         end
         if (n >= 16 && n < 144 && ((n - 16) % 16) == 8) rx[(n - 16) / 16] = TxD;
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_in_frame byte=%h got %b want 1", b, busy);
      end
      checks++;
      if (rx !== b) begin
         errors++;
         $display("FAIL frame_decode got %h want %h", rx, b);
      end
      $display("frame sent=%h decoded=%h", b, rx);
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (TxD !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL %s got txd=%b busy=%b count=%0d want txd=1 busy=0 count=0",
                  tag, TxD, busy, fifo_count);
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (TxD !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got txd=%b ready=%b busy=%b count=%0d want 1 1 0 0",
                  TxD, ready, busy, fifo_count);
      end
      @(negedge clock);
      reset = 1'b1;
      $display("reset checked");
   endtask

   task automatic test_single();
      apply_reset();
      wr(8'h55);
      checks++;
      if (fifo_count !== 3'd1 || busy !== 1'b1 || TxD !== 1'b1) begin
         errors++;
         $display("FAIL single_queued got count=%0d busy=%b txd=%b want 1 1 1",
                  fifo_count, busy, TxD);
      end
      run_frame(8'h55);
      tick_once();
      check_idle("single_end");
   endtask

   task automatic test_latency();
      apply_reset();
      write = 1'b1; data_in = 8'h33; uart_tick_16x = 1'b1;
      @(negedge clock);
      write = 1'b0; uart_tick_16x = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (TxD !== 1'b1 || fifo_count !== 3'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_no_start got txd=%b count=%0d busy=%b want 1 1 1",
                  TxD, fifo_count, busy);
      end
      run_frame(8'h33);
      tick_once();
      check_idle("latency_end");
   endtask

   task automatic test_back_to_back();
      apply_reset();
      wr(8'hA5);
      wr(8'h3C);
      checks++;
      if (fifo_count !== 3'd2) begin
         errors++;
         $display("FAIL b2b_count got %0d want 2", fifo_count);
      end
      run_frame(8'hA5);
      checks++;
      if (fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL b2b_pending got %0d want 1", fifo_count);
      end
      run_frame(8'h3C);
      tick_once();
      check_idle("b2b_end");
   endtask

   task automatic test_overflow();
      logic       exp_ready;
      logic [2:0] exp_count;
      apply_reset();
      for (int k = 0; k < 6; k++) begin
         write   = 1'b1;
         data_in = 8'h10 + 8'(k);
         @(negedge clock);
         exp_ready = (k + 1 < 4);
         exp_count = (k + 1 < 4) ? 3'(k + 1) : 3'd4;
         checks++;
         if (ready !== exp_ready || fifo_count !== exp_count) begin
            errors++;
            $display("FAIL overflow_write%0d got ready=%b count=%0d want ready=%b count=%0d",
                     k, ready, fifo_count, exp_ready, exp_count);
         end
      end
      write = 1'b0;
      for (int k = 0; k < 4; k++) run_frame(8'h10 + 8'(k));
      tick_once();
      check_idle("overflow_end");
      for (int k = 0; k < 20; k++) tick_once();
      check_idle("overflow_no_fifth");
   endtask

   task automatic test_simultaneous();
      apply_reset();
      wr(8'h21);
      wr(8'h22);
      wr(8'h23);
      run_frame(8'h21);
      checks++;
      if (fifo_count !== 3'd2) begin
         errors++;
         $display("FAIL simul_before got %0d want 2", fifo_count);
      end
      write = 1'b1; data_in = 8'h24; uart_tick_16x = 1'b1;
      @(negedge clock);
      write = 1'b0; uart_tick_16x = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (fifo_count !== 3'd2 || TxD !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL simul_push_pop got count=%0d txd=%b busy=%b want 2 0 1",
                  fifo_count, TxD, busy);
      end
      $display("simultaneous push/pop count=%0d", fifo_count);
   endtask

   task automatic test_reset_mid_frame();
      logic saw_low;
      apply_reset();
      wr(8'hF0);
      tick_once();
      wr(8'h99);
      for (int n = 1; n <= 69; n++) tick_once();
      checks++;
      if (TxD !== 1'b0 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL midframe_pre got txd=%b count=%0d want 0 1", TxD, fifo_count);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (TxD !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL midframe_async got txd=%b count=%0d busy=%b ready=%b want 1 0 0 1",
                  TxD, fifo_count, busy, ready);
      end
      @(negedge clock);
      reset = 1'b1;
      saw_low = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick_once();
         if (TxD !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
      end
      checks++;
      if (saw_low !== 1'b0) begin
         errors++;
         $display("FAIL midframe_restart got activity=%b want 0", saw_low);
      end
      wr(8'h5A);
      run_frame(8'h5A);
      tick_once();
      check_idle("midframe_end");
   endtask

   task automatic test_loopback();
      logic [7:0] pat [4];
      pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h81; pat[3] = 8'h7E;
      apply_reset();
      for (int k = 0; k < 4; k++) wr(pat[k]);
      for (int k = 0; k < 4; k++) run_frame(pat[k]);
      tick_once();
      check_idle("loopback_end");
   endtask

   initial begin
      reset         = 1'b0;
      uart_tick_16x = 1'b0;
      write         = 1'b0;
      data_in       = 8'h00;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      test_reset();
      test_single();
      test_latency();
      test_back_to_back();
      test_overflow();
      test_simultaneous();
      test_reset_mid_frame();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
